// File: rtl/noc_route_select.sv
// rtl/noc_route_select.sv - header/body route-bit extraction feeding a 2-entry {sel, flit} output FIFO
// Optional ROUTE_HDR_ROTATE_EN: rotate header payload right by one so the next tree level reads the same bit index.
module noc_route_select #(
    parameter int ADDR_BIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [8:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [8:0]       out_data,
    output logic             out_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pkt_count
);

    typedef enum logic {HEAD = 1'b0, BODY = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q;
    logic [9:0]       mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       occ_q;

    logic             push, pop;
    logic             push_sel;
    logic [8:0]       push_data;

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_sel   = mem_q[rd_ptr_q][9];
    assign out_data  = mem_q[rd_ptr_q][8:0];
    assign pkt_count = cnt_q;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        push_sel  = sel_q;
        push_data = in_data;
        if (push) begin
            case (state_q)
                HEAD: begin
                    // route bit always comes from the unrotated header
                    sel_d    = in_data[ADDR_BIT];
                    push_sel = in_data[ADDR_BIT];
`ifdef ROUTE_HDR_ROTATE_EN
                    push_data = {in_data[8], in_data[0], in_data[7:1]};
`else
                    push_data = in_data;
`endif
                    state_d  = in_data[8] ? HEAD : BODY;
                end
                BODY: begin
                    state_d = in_data[8] ? HEAD : BODY;
                end
                default: state_d = HEAD;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= HEAD;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else if (push && in_data[8] && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {push_sel, push_data};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_route_select.sv
// tb/tb_noc_route_select.sv - scoreboard bench for noc_route_select (CNT_W=3 to reach saturation quickly)
module tb_noc_route_select;

    localparam int ADDR_BIT = 0;
    localparam int CNT_W    = 3;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic [8:0]       in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [8:0]       out_data;
    logic             out_sel;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] pkt_count;

    noc_route_select #(.ADDR_BIT(ADDR_BIT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
        .pkt_count(pkt_count)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int pops = 0;

    logic [9:0] sb [$];
    logic       m_head = 1'b1;
    logic       m_sel = 1'b0;
    int         m_cnt = 0;
    logic       held_v = 1'b0;
    logic [8:0] held_d;
    logic       held_s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] model_hdr(input logic [8:0] f);
        logic [8:0] r;
        r = f;
`ifdef ROUTE_HDR_ROTATE_EN
        for (int i = 0; i < 8; i++) r[i] = f[(i + 1) % 8];
`endif
        return r;
    endfunction

    // Inputs change at posedge+1, so the negedge sees the values the next edge will act on
    always @(negedge CLK) begin
        if (RESET) begin
            sb.delete();
            m_head = 1'b1;
            m_sel  = 1'b0;
            m_cnt  = 0;
            held_v = 1'b0;
        end else begin
            check("pkt_count", 32'(pkt_count), 32'(m_cnt));
            if (held_v) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(held_d));
                check("hold_sel", 32'(out_sel), 32'(held_s));
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_s = out_sel;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 32'(sb.size()), 32'd1);
                end else begin
                    logic [9:0] e;
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e[8:0]));
                    check("out_sel", 32'(out_sel), 32'(e[9]));
                    pops++;
                end
            end
            if (in_valid && in_ready) begin
                if (m_head) begin
                    m_sel = in_data[ADDR_BIT];
                    sb.push_back({m_sel, model_hdr(in_data)});
                end else begin
                    sb.push_back({m_sel, in_data});
                end
                m_head = in_data[8];
                if (in_data[8] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
        end
    end

    task automatic send(input logic [8:0] f);
        logic ok;
        int   n;
        in_data  = f;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            ok = in_ready;
            @(posedge CLK);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        int p0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        tick(2);
        RESET = 1'b0;
        out_ready = 1'b1;
        tick(1);

        send(9'h105);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'h105);
        check("t1_sel", 32'(out_sel), 32'd1);
        check("t1_cnt", 32'(pkt_count), 32'd1);
        tick(1);

        p0 = pops;
        send(9'h002); send(9'h0AA); send(9'h1FF);
        tick(1);
        check("t2_throughput", 32'(pops - p0), 32'd3);

        send(9'h101); send(9'h100);
        send(9'h000); send(9'h0FF); send(9'h100);
        tick(2);

        out_ready = 1'b0;
        send(9'h011); send(9'h010);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        in_data  = 9'h112;
        in_valid = 1'b1;
        tick(3);
        check("bp_still_low", 32'(in_ready), 32'd0);
        check("bp_head_data", 32'(out_data), 32'h011);
        out_ready = 1'b1;
        send(9'h112);
        tick(3);

        out_ready = 1'b0;
        send(9'h001);
        RESET = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_cnt", 32'(pkt_count), 32'd0);
        tick(2);
        RESET = 1'b0;
        out_ready = 1'b1;
        send(9'h100);
        check("post_rst_sel", 32'(out_sel), 32'd0);
        check("post_rst_data", 32'(out_data), 32'h100);
        tick(1);

        send(9'h006);
        check("rot_sel", 32'(out_sel), 32'd0);
`ifdef ROUTE_HDR_ROTATE_EN
        check("rot_data", 32'(out_data), 32'h003);
`else
        check("rot_data", 32'(out_data), 32'h006);
`endif
        send(9'h100);

        for (int i = 0; i < 8; i++) send(9'h100 | 9'($urandom_range(0, 255)));
        tick(3);
        check("cnt_saturated", 32'(pkt_count), 32'd7);

        out_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/noc_route_select.md
# noc_route_select

Synchronous route-select stage placed directly upstream of the decoder10 leaf. It accepts 9-bit flits over a valid/ready channel and tracks packet boundaries with a header/body state machine. It extracts the route bit from each header flit and emits every flit of the packet paired with that select bit, so the downstream leaf receives In and S together. A 2-entry output FIFO decouples the stages.

## Interface
- `ADDR_BIT`, default 0: bit index within header payload `[7:0]` used as the route bit; legal range 0..7.
- `CNT_W`, default 16: width of the packet counter.
- `CLK` input, 1 bit: clock; all state changes on the rising edge.
- `RESET` input, 1 bit: asynchronous, active-high reset.
- `in_data` input, 9 bits: flit; `[8]` = tail flag, `[7:0]` = payload (destination address on the header flit).
- `in_valid` input, 1 bit: upstream flit valid.
- `in_ready` output, 1 bit: stage can accept a flit.
- `out_data` output, 9 bits: flit to the decoder leaf In channel.
- `out_sel` output, 1 bit: route select to the decoder leaf S channel (0 → Out0, 1 → Out1).
- `out_valid` output, 1 bit: `out_data`/`out_sel` valid.
- `out_ready` input, 1 bit: downstream accepts.
- `pkt_count` output, CNT_W bits: number of tail flits accepted, saturating.

## Operation
- Handshake: a transfer occurs on a rising edge where valid && ready. Once `out_valid` is asserted, `out_data` and `out_sel` are held stable until the transfer completes.
- FSM states:
  - HEAD (reset state): an accepted flit is a header. Route bit `r = in_data[ADDR_BIT]` is latched into `sel_q`, and the flit is pushed with select `r`. If `in_data[8]=1` (single-flit packet), the FSM stays in HEAD; otherwise it goes to BODY.
  - BODY: an accepted flit is pushed with select `sel_q`. If `in_data[8]=1`, the FSM returns to HEAD; otherwise it stays in BODY.
- Body flit payloads are never interpreted as addresses.
- FIFO: 2 entries of `{sel, data[8:0]}`, in order. `in_ready = !full`, registered from FIFO occupancy with no combinational path from `out_ready`.
- Push and pop in the same cycle are allowed at occupancy 1. At occupancy 2, no push is possible because `in_ready=0`.
- `pkt_count` increments by 1 on each accepted flit with `[8]=1`. It saturates at all-ones and never wraps.
- Reset mid-packet: the FSM returns to HEAD, FIFO contents are discarded, and `sel_q` and `pkt_count` are cleared. The first flit accepted after reset is treated as a header.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_sel=0`, `in_ready=1`, `pkt_count=0`, FSM = HEAD, `sel_q=0`.
- Latency: a flit accepted at edge N is presented with `out_valid=1` after edge N, and is transferable at edge N+1.
- Throughput: 1 flit/cycle sustained while `out_ready=1`.
- Backpressure: with `out_ready=0`, two flits are accepted, then `in_ready` deasserts after the second edge. `in_ready` reasserts the cycle after the first pop.
- `pkt_count` updates on the same edge as the tail flit is accepted.

## Configuration
- `ROUTE_HDR_ROTATE_EN` defined: header payload `[7:0]` is rotated right by one bit position as it is pushed into the FIFO. Bit `ADDR_BIT+1` (mod 8) moves into position `ADDR_BIT`, so the next tree level reads the same index. Body flits and the tail flag are unchanged.
- Not defined: all flits pass through unmodified.
- Route-bit extraction always uses the unrotated incoming header.

## Test plan
- Reset release, then single-flit packet `9'h105` (tail=1, addr bit0=1), `out_ready=1` → next cycle `out_data=9'h105`, `out_sel=1`, `pkt_count=1`, FSM in HEAD.
- 3-flit packet `9'h002, 9'h0AA, 9'h1FF` with `ADDR_BIT=0` → three outputs in order, all `out_sel=0`, 1 flit/cycle, `pkt_count=1`.
- Back-to-back packets `9'h101` then `9'h100` → `out_sel` = 1 then 0; a body flit `9'h0FF` inside a sel=0 packet must not flip `out_sel`.
- `out_ready=0`, drive 3 flits → `in_ready` drops after 2 are accepted. Raise `out_ready` → all 3 flits delivered in order with stable data while stalled.
- Assert `RESET` after header `9'h001` is accepted but before its tail → outputs return to reset values. Next flit `9'h100` is treated as a header with `out_sel=0`.
- With `ROUTE_HDR_ROTATE_EN`, header `9'h006`, `ADDR_BIT=0` → `out_sel=0`, `out_data=9'h003`. Without the macro → `out_data=9'h006`.
